plru_replacement_engine: RTL and testbench

//  Per-set tree pseudo-LRU replacement engine for the LLC, parametrised in associativity and set count.

---
 rtl/plru_replacement_engine_pkg.sv | 13 +
 rtl/plru_replacement_engine_tree_update.sv | 42 ++++
 rtl/plru_replacement_engine.sv | 138 +++++++++++++
 tb/tb_plru_replacement_engine.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/plru_replacement_engine_pkg.sv
// plru_replacement_engine_pkg: shared op/state types and defaults for the tree-PLRU engine
package plru_replacement_engine_pkg;
    localparam int DEF_ASSOCIATIVITY = 16;
    localparam int DEF_SETS = 16384;
    typedef enum logic [1:0] {OP_TOUCH, OP_FILL, OP_PEEK, OP_RSVD} plru_op_t;
    typedef enum logic {ST_INIT, ST_RUN} plru_state_t;
    function automatic int pseudo_lru_bits(input int assoc);
        return assoc - 1;
    endfunction
    function automatic logic op_writes(input plru_op_t op);
        return op == OP_TOUCH || op == OP_FILL;
    endfunction
endpackage

// File: rtl/plru_replacement_engine_tree_update.sv
// plru_tree_update: combinational victim pick and path update for one heap-ordered PLRU tree
module plru_tree_update
    import plru_replacement_engine_pkg::*;
#(
    parameter int ASSOCIATIVITY = DEF_ASSOCIATIVITY,
    localparam int WAY_BITS = $clog2(ASSOCIATIVITY),
    localparam int PSEUDO_LRU = pseudo_lru_bits(ASSOCIATIVITY)
) (
    input  logic [PSEUDO_LRU-1:0]    bits,
    input  logic [ASSOCIATIVITY-1:0] mask,
    input  plru_op_t                 op,
    input  logic [WAY_BITS-1:0]      way,
    output logic [WAY_BITS-1:0]      victim,
    output logic                     invalid_used,
    output logic [PSEUDO_LRU-1:0]    new_bits
);
    int node;
    logic dir;
    logic [WAY_BITS-1:0] target;
    always_comb begin
        node = 0;
        dir = 1'b0;
        victim = '0;
        invalid_used = ~&mask;
        for (int i = ASSOCIATIVITY - 1; i >= 0; i--)
            if (!mask[i]) victim = WAY_BITS'(i);
        if (!invalid_used) begin
            for (int l = 0; l < WAY_BITS; l++)
                node = 2 * node + 1 + int'(bits[node[WAY_BITS-1:0]]);
            victim = WAY_BITS'(node - (ASSOCIATIVITY - 1));
        end
        target = (op == OP_TOUCH) ? way : victim;
        new_bits = bits;
        node = 0;
        // each node on the path is flipped to point at the sibling subtree
        for (int l = 0; l < WAY_BITS; l++) begin
            dir = target[WAY_BITS-1-l];
            new_bits[node[WAY_BITS-1:0]] = ~dir;
            node = 2 * node + 1 + int'(dir);
        end
    end
endmodule

// File: rtl/plru_replacement_engine.sv
// plru_replacement_engine: per-set tree-PLRU state with a 2-stage read/modify/write pipeline
module plru_replacement_engine
    import plru_replacement_engine_pkg::*;
#(
    parameter int ASSOCIATIVITY = DEF_ASSOCIATIVITY,
    parameter int SETS = DEF_SETS,
    localparam int WAY_BITS = $clog2(ASSOCIATIVITY),
    localparam int INDEX = $clog2(SETS),
    localparam int PSEUDO_LRU = pseudo_lru_bits(ASSOCIATIVITY)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [INDEX-1:0]         req_index,
    input  logic [WAY_BITS-1:0]      req_way,
    input  logic [ASSOCIATIVITY-1:0] req_valid_mask,
    output logic                     rsp_valid,
    output logic [WAY_BITS-1:0]      rsp_way,
    output logic                     rsp_invalid,
    output logic                     init_done
);
    plru_state_t state_q, state_d;
    logic [INDEX-1:0] init_cnt_q, init_cnt_d;
    logic s1_valid_q, s1_valid_d;
    plru_op_t s1_op_q, s1_op_d;
    logic [INDEX-1:0] s1_index_q, s1_index_d;
    logic [WAY_BITS-1:0] s1_way_q, s1_way_d;
    logic [ASSOCIATIVITY-1:0] s1_mask_q, s1_mask_d;
    logic s2_valid_q, s2_valid_d;
    plru_op_t s2_op_q, s2_op_d;
    logic [INDEX-1:0] s2_index_q, s2_index_d;
    logic [WAY_BITS-1:0] s2_way_q, s2_way_d;
    logic [ASSOCIATIVITY-1:0] s2_mask_q, s2_mask_d;
    logic s2_fwd_q, s2_fwd_d;
    logic [PSEUDO_LRU-1:0] s2_fwd_bits_q, s2_fwd_bits_d;
    logic rsp_valid_q, rsp_valid_d;
    logic [WAY_BITS-1:0] rsp_way_q, rsp_way_d;
    logic rsp_invalid_q, rsp_invalid_d;
    logic [PSEUDO_LRU-1:0] plru_mem [SETS];
    logic [PSEUDO_LRU-1:0] rd_bits_q;
    logic [PSEUDO_LRU-1:0] s2_bits, new_bits, mem_wdata;
    logic [WAY_BITS-1:0] victim;
    logic invalid_used, s2_wr, mem_we;
    logic [INDEX-1:0] mem_waddr;

    assign init_done = state_q == ST_RUN;
    assign req_ready = init_done;
    assign rsp_valid = rsp_valid_q;
    assign rsp_way = rsp_way_q;
    assign rsp_invalid = rsp_invalid_q;
    // a same-set write landing on the edge S1's read happens makes that read stale
    assign s2_bits = s2_fwd_q ? s2_fwd_bits_q : rd_bits_q;
    assign s2_wr = s2_valid_q && op_writes(s2_op_q);
    assign mem_we = (state_q == ST_INIT) || s2_wr;
    assign mem_waddr = (state_q == ST_INIT) ? init_cnt_q : s2_index_q;
    assign mem_wdata = (state_q == ST_INIT) ? '0 : new_bits;

    plru_tree_update #(.ASSOCIATIVITY(ASSOCIATIVITY)) u_tree (
        .bits        (s2_bits),
        .mask        (s2_mask_q),
        .op          (s2_op_q),
        .way         (s2_way_q),
        .victim      (victim),
        .invalid_used(invalid_used),
        .new_bits    (new_bits)
    );

    always_comb begin
        state_d = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == INDEX'(SETS - 1)) state_d = ST_RUN;
        end
        s1_valid_d = req_valid && req_ready;
        s1_op_d = plru_op_t'(req_op);
        s1_index_d = req_index;
        s1_way_d = req_way;
        s1_mask_d = req_valid_mask;
        s2_valid_d = s1_valid_q;
        s2_op_d = s1_op_q;
        s2_index_d = s1_index_q;
        s2_way_d = s1_way_q;
        s2_mask_d = s1_mask_q;
        s2_fwd_d = s2_wr && (s2_index_q == s1_index_q);
        s2_fwd_bits_d = new_bits;
        rsp_valid_d = s2_valid_q;
        rsp_way_d = !s2_valid_q ? '0 : (s2_op_q == OP_TOUCH ? s2_way_q : victim);
        rsp_invalid_d = s2_valid_q && (s2_op_q != OP_TOUCH) && invalid_used;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            init_cnt_q <= '0;
            s1_valid_q <= 1'b0;
            s1_op_q <= OP_TOUCH;
            s1_index_q <= '0;
            s1_way_q <= '0;
            s1_mask_q <= '0;
            s2_valid_q <= 1'b0;
            s2_op_q <= OP_TOUCH;
            s2_index_q <= '0;
            s2_way_q <= '0;
            s2_mask_q <= '0;
            s2_fwd_q <= 1'b0;
            s2_fwd_bits_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_way_q <= '0;
            rsp_invalid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            init_cnt_q <= init_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_op_q <= s1_op_d;
            s1_index_q <= s1_index_d;
            s1_way_q <= s1_way_d;
            s1_mask_q <= s1_mask_d;
            s2_valid_q <= s2_valid_d;
            s2_op_q <= s2_op_d;
            s2_index_q <= s2_index_d;
            s2_way_q <= s2_way_d;
            s2_mask_q <= s2_mask_d;
            s2_fwd_q <= s2_fwd_d;
            s2_fwd_bits_q <= s2_fwd_bits_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_way_q <= rsp_way_d;
            rsp_invalid_q <= rsp_invalid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) plru_mem[mem_waddr] <= mem_wdata;
        rd_bits_q <= plru_mem[s1_index_q];
    end
endmodule

// File: tb/tb_plru_replacement_engine.sv
// tb_plru_replacement_engine: directed + random checks of the PLRU engine against a per-set tree model
module tb_plru_replacement_engine;
    localparam int A = 16;
    localparam int WB = 4;
    localparam int SETS = 16384;
    localparam int IDX = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [1:0] req_op = '0;
    logic [IDX-1:0] req_index = '0;
    logic [WB-1:0] req_way = '0;
    logic [A-1:0] req_valid_mask = '1;
    logic rsp_valid;
    logic [WB-1:0] rsp_way;
    logic rsp_invalid;
    logic init_done;

    always #5 clk = ~clk;

    plru_replacement_engine #(.ASSOCIATIVITY(A), .SETS(SETS)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_index(req_index), .req_way(req_way),
        .req_valid_mask(req_valid_mask), .rsp_valid(rsp_valid), .rsp_way(rsp_way),
        .rsp_invalid(rsp_invalid), .init_done(init_done)
    );

    typedef struct {int due; int way; int inv; int lit_way; int lit_inv;} exp_t;
    exp_t q[$];
    exp_t e;
    logic [A-2:0] mdl [int];
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lowest_invalid(input logic [A-1:0] m);
        for (int i = 0; i < A; i++) if (!m[i]) return i;
        return -1;
    endfunction

    // node at level l above a way prefix p is (2^l - 1) + p in heap order
    function automatic int tree_victim(input logic [A-2:0] b);
        int w = 0;
        for (int l = 0; l < WB; l++) w = 2 * w + int'(b[(1 << l) - 1 + w]);
        return w;
    endfunction

    function automatic logic [A-2:0] point_away(input logic [A-2:0] b, input int w);
        for (int l = 0; l < WB; l++)
            b[(1 << l) - 1 + (w >> (WB - l))] = ((w >> (WB - 1 - l)) & 1) == 0;
        return b;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        chk("ready_eq_init_done", req_ready, init_done);
        if (!rst_n) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_way", rsp_way, 0);
            chk("rst_rsp_invalid", rsp_invalid, 0);
            chk("rst_req_ready", req_ready, 0);
        end else if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_way", rsp_way, e.way);
            chk("rsp_invalid", rsp_invalid, e.inv);
            if (e.lit_way >= 0) begin
                chk("lit_rsp_way", rsp_way, e.lit_way);
                chk("lit_rsp_invalid", rsp_invalid, e.lit_inv);
            end
        end else begin
            chk("idle_rsp_valid", rsp_valid, 0);
        end
    end

    task automatic issue(input int op, input int idx, input int w, input logic [A-1:0] m,
                         input int lw = -1, input int li = -1);
        logic [A-2:0] b;
        int rw, ri, n;
        req_valid = 1'b1;
        req_op = op[1:0];
        req_index = idx[IDX-1:0];
        req_way = w[WB-1:0];
        req_valid_mask = m;
        n = 0;
        while (!req_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        b = mdl.exists(idx) ? mdl[idx] : '0;
        if (op == 0) begin
            rw = w;
            ri = 0;
            b = point_away(b, w);
        end else begin
            rw = lowest_invalid(m);
            ri = (rw >= 0) ? 1 : 0;
            if (rw < 0) rw = tree_victim(b);
            if (op == 1) b = point_away(b, rw);
        end
        mdl[idx] = b;
        q.push_back('{cyc + 3, rw, ri, lw, li});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < SETS + 20) begin
            @(negedge clk);
            n++;
        end
        chk("reinit_ready", req_ready, 1);
    endtask

    initial begin
        int cnt;
        logic [A-1:0] m;
        req_valid = 1'b1;
        req_op = 2'd1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        while (!req_ready && cnt < SETS + 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("init_cycles", cnt, SETS);
        @(negedge clk);
        req_valid = 1'b0;
        idle(2);

        issue(1, 5, 0, '1, 0, 0);
        idle(2);
        issue(1, 5, 0, '1, 8, 0);
        idle(3);
        issue(1, 5, 0, '1, 4, 0);
        idle(1);
        issue(1, 5, 0, '1, 12, 0);
        idle(3);

        issue(1, 7, 0, 16'hFFF7, 3, 1);
        idle(2);
        issue(2, 7, 0, '1, 8, 0);
        idle(3);

        issue(1, 9, 0, '1, 0, 0);
        issue(1, 9, 0, '1, 8, 0);
        issue(1, 11, 0, '1, 0, 0);
        issue(1, 10, 0, '1, 0, 0);
        idle(3);

        issue(0, 2, 0, '1, 0, 0);
        issue(2, 2, 0, '1, 8, 0);
        issue(2, 2, 0, '1, 8, 0);
        issue(1, 2, 0, '1, 8, 0);
        issue(2, 2, 0, '1, 4, 0);
        idle(3);

        issue(0, 3, 5, 16'h0000, 5, 0);
        issue(3, 4, 0, '1, 0, 0);
        issue(2, 4, 0, '1, 0, 0);
        issue(1, 12, 0, 16'h7FFF, 15, 1);
        idle(3);

        for (int i = 0; i < 4000; i++) begin
            m = ($urandom % 3 == 0) ? A'($urandom) :
                ($urandom % 5 == 0) ? ~(A'(1) << $urandom_range(0, A - 1)) : '1;
            issue($urandom_range(0, 3),
                  ($urandom % 4 == 0) ? $urandom_range(0, SETS - 1) : $urandom_range(0, 7),
                  $urandom_range(0, A - 1), m);
            if ($urandom % 4 == 0) idle($urandom_range(1, 3));
        end
        idle(4);

        issue(1, 5, 0, '1);
        issue(1, 6, 0, '1);
        rst_n = 1'b0;
        q.delete();
        mdl.delete();
        idle(3);
        rst_n = 1'b1;
        wait_ready();
        issue(1, 5, 0, '1, 0, 0);
        idle(4);

        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
